load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_range_check.sv | 15 +
 rtl/load_store_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: state encoding,
// default legal data window and datapath widths.
package lsu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_LO_DEF = 8'd64;
    localparam logic [ADDR_W-1:0] ADDR_HI_DEF = 8'd127;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_range_check.sv
// Combinational in-window compare; with CHECK_EN cleared every address is legal.
module lsu_range_check
    import lsu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_LO  = ADDR_LO_DEF,
    parameter logic [ADDR_W-1:0] ADDR_HI  = ADDR_HI_DEF,
    parameter bit                CHECK_EN = 1'b1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    assign in_range = CHECK_EN ? ((addr >= ADDR_LO) && (addr <= ADDR_HI)) : 1'b1;

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with an address window check.
// Define LSU_BOUNDS_CHECK_EN to enable the window check, resp_err and fault_count.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_LO = ADDR_LO_DEF,
    parameter logic [ADDR_W-1:0] ADDR_HI = ADDR_HI_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [7:0]        fault_count,
    output logic [ADDR_W-1:0] data_address,
    output logic [DATA_W-1:0] write_data,
    output logic              write_enable,
    input  logic [DATA_W-1:0] read_data
);

`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    lsu_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_q;
    logic              is_store_q;
    logic              err_q;
    logic [ADDR_W-1:0] data_address_q;
    logic              handshake;
    logic              addr_ok;

    assign handshake = req_valid && (state_q == ST_IDLE);

    // The window check looks at the address exactly as it will be latched.
    assign addr_d = handshake ? req_addr : addr_q;

    lsu_range_check #(
        .ADDR_LO  (ADDR_LO),
        .ADDR_HI  (ADDR_HI),
        .CHECK_EN (CHECK_EN)
    ) u_range_check (
        .addr     (addr_d),
        .in_range (addr_ok)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            is_store_q     <= 1'b0;
            err_q          <= 1'b0;
            data_address_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        is_store_q <= req_is_store;
                        if (addr_ok) begin
                            err_q          <= 1'b0;
                            data_address_q <= req_addr;
                            state_q        <= req_is_store ? ST_WR : ST_RD;
                        end else begin
                            // Faults skip the memory entirely and keep the old address.
                            err_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_RD:   state_q <= ST_RESP;
                ST_WR:   state_q <= ST_RESP;
                ST_RESP: begin
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef LSU_BOUNDS_CHECK_EN
    logic [7:0] fault_count_q;

    // Counted on the edge that enters RESP with an error pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_count_q <= '0;
        end else if (handshake && !addr_ok && (fault_count_q != 8'hFF)) begin
            fault_count_q <= fault_count_q + 8'd1;
        end
    end

    assign fault_count = fault_count_q;
    assign resp_err    = resp_valid && err_q;
`else
    assign fault_count = '0;
    assign resp_err    = 1'b0;
`endif

    assign req_ready    = (state_q == ST_IDLE);
    // Gated by rst_n so a reset edge can neither commit a write nor report completion.
    assign resp_valid   = (state_q == ST_RESP) && rst_n;
    assign write_enable = (state_q == ST_WR) && rst_n;
    assign write_data   = (state_q == ST_WR) ? wdata_q : '0;
    assign data_address = data_address_q;
    assign resp_rdata   = (resp_valid && !is_store_q && !err_q) ? read_data : '0;

endmodule
